// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg
// Shared types and constants for the multi-cycle control unit.
//   state_t        : sequencing states of the control FSM
//   instr_class_t  : coarse instruction class produced by the decoder
//   ctrl_word_t    : datapath select word captured once per instruction
//   FUNC_* / OP_*  : R-type function codes and I-type opcodes
//   ALU_*          : ALU operation codes (ALU_NOP is all-ones = pass)
// ---------------------------------------------------------------------------
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_IO,
        CL_ILLEGAL
    } instr_class_t;

    // R-type function field values (bit INSTR_W-1 = 0)
    localparam int FUNC_NOP = 0;
    localparam int FUNC_ADD = 1;
    localparam int FUNC_SUB = 2;
    localparam int FUNC_AND = 3;
    localparam int FUNC_OR  = 4;
    localparam int FUNC_XOR = 5;
    localparam int FUNC_SLT = 6;

    // I-type opcode field values (bit INSTR_W-1 = 1)
    localparam int OP_ADDI  = 0;
    localparam int OP_LOAD  = 1;
    localparam int OP_STORE = 2;
    localparam int OP_BEQ   = 3;
    localparam int OP_LI    = 4;
    localparam int OP_SEG   = 5;
    localparam int OP_LED   = 6;

    // ALU operation codes; ALU_NOP is -1 so a sized cast gives all-ones at any width
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_AND = 2;
    localparam int ALU_OR  = 3;
    localparam int ALU_XOR = 4;
    localparam int ALU_SLT = 5;
    localparam int ALU_NOP = -1;

    // Datapath select word; segWe/ledWe mark which display an IO instruction writes
    typedef struct packed {
        logic       imaddSl;
        logic       rbData1Sl;
        logic [1:0] rbDatainSl;
        logic [1:0] aluDataSl;
        logic [1:0] segSl;
        logic [1:0] ledSl;
        logic       segWe;
        logic       ledWe;
    } ctrl_word_t;

endpackage

// File: rtl/control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Pure combinational instruction classifier. Maps one fetched instruction to
// its class, the datapath select word and the ALU operation.
//   instr_i  in   INSTR_W   instruction from instruction memory
//   class_o  out  class     NOP / ALU / LOAD / STORE / BRANCH / IO / ILLEGAL
//   ctrl_o   out  struct    register-bank, ALU, 7-seg and LED selects
//   aluOp_o  out  ALU_OP_W  ALU operation, all-ones for pass/no-op
// Select encodings: rbDatainSl 0=ALU 1=memory 2=immediate; aluDataSl 0=reg 1=imm;
// segSl/ledSl 1=register read port; imaddSl 1=branch target.
// ---------------------------------------------------------------------------
module control_decode
    import cu_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int FUNC_W   = 9,
    parameter int OP_W     = 4,
    parameter int ALU_OP_W = 4
) (
    input  logic [INSTR_W-1:0]  instr_i,
    output instr_class_t        class_o,
    output ctrl_word_t          ctrl_o,
    output logic [ALU_OP_W-1:0] aluOp_o
);

    logic [FUNC_W-1:0] func;
    logic [OP_W-1:0]   opcode;
    logic              unusedInstrBits;

    assign func   = instr_i[INSTR_W-2 -: FUNC_W];
    assign opcode = instr_i[INSTR_W-2 -: OP_W];

    // Low operand bits are consumed by the datapath, not by the controller
    assign unusedInstrBits = ^instr_i[INSTR_W-2-FUNC_W:0];

    // Classify the instruction; anything not listed decodes as ILLEGAL
    always_comb begin
        class_o = CL_ILLEGAL;
        ctrl_o  = '0;
        aluOp_o = ALU_OP_W'(ALU_NOP);
        if (!instr_i[INSTR_W-1]) begin
            case (func)
                FUNC_W'(FUNC_NOP): class_o = CL_NOP;
                FUNC_W'(FUNC_ADD): begin
                    class_o = CL_ALU;
                    aluOp_o = ALU_OP_W'(ALU_ADD);
                end
                FUNC_W'(FUNC_SUB): begin
                    class_o = CL_ALU;
                    aluOp_o = ALU_OP_W'(ALU_SUB);
                end
                FUNC_W'(FUNC_AND): begin
                    class_o = CL_ALU;
                    aluOp_o = ALU_OP_W'(ALU_AND);
                end
                FUNC_W'(FUNC_OR): begin
                    class_o = CL_ALU;
                    aluOp_o = ALU_OP_W'(ALU_OR);
                end
                FUNC_W'(FUNC_XOR): begin
                    class_o = CL_ALU;
                    aluOp_o = ALU_OP_W'(ALU_XOR);
                end
                FUNC_W'(FUNC_SLT): begin
                    class_o = CL_ALU;
                    aluOp_o = ALU_OP_W'(ALU_SLT);
                end
                default: class_o = CL_ILLEGAL;
            endcase
        end else begin
            case (opcode)
                OP_W'(OP_ADDI): begin
                    class_o          = CL_ALU;
                    aluOp_o          = ALU_OP_W'(ALU_ADD);
                    ctrl_o.aluDataSl = 2'd1;
                end
                OP_W'(OP_LOAD): begin
                    class_o           = CL_LOAD;
                    aluOp_o           = ALU_OP_W'(ALU_ADD);
                    ctrl_o.aluDataSl  = 2'd1;
                    ctrl_o.rbDatainSl = 2'd1;
                end
                OP_W'(OP_STORE): begin
                    class_o          = CL_STORE;
                    aluOp_o          = ALU_OP_W'(ALU_ADD);
                    ctrl_o.aluDataSl = 2'd1;
                    ctrl_o.rbData1Sl = 1'b1;
                end
                OP_W'(OP_BEQ): begin
                    class_o        = CL_BRANCH;
                    aluOp_o        = ALU_OP_W'(ALU_SUB);
                    ctrl_o.imaddSl = 1'b1;
                end
                OP_W'(OP_LI): begin
                    class_o           = CL_ALU;
                    ctrl_o.rbDatainSl = 2'd2;
                end
                OP_W'(OP_SEG): begin
                    class_o      = CL_IO;
                    ctrl_o.segSl = 2'd1;
                    ctrl_o.segWe = 1'b1;
                end
                OP_W'(OP_LED): begin
                    class_o      = CL_IO;
                    ctrl_o.ledSl = 2'd1;
                    ctrl_o.ledWe = 1'b1;
                end
                default: class_o = CL_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the lab datapath.
//   clk, rst_n          clock, synchronous active-low reset
//   stall               freeze FSM/counters, suppress strobes
//   im_req/im_valid/instr         instruction-memory handshake
//   ir_we, pc_we, rb_we, seg_we, led_we   one-cycle write strobes
//   branch, imadd_sl, rb_data1_sl, rb_datain_sl, alu_data_sl,
//   alu_op, seg_sl, led_sl        datapath selects, stable DECODE..WB
//   dm_req/dm_we/dm_ready         data-memory handshake
//   illegal, bus_err              sticky error flags
//   halted                        FSM parked in HALT until reset
// ---------------------------------------------------------------------------
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int INSTR_W     = 16,
    parameter int FUNC_W      = 9,
    parameter int OP_W        = 4,
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    output logic                im_req,
    input  logic                im_valid,
    input  logic [INSTR_W-1:0]  instr,
    output logic                ir_we,
    output logic                pc_we,
    output logic                branch,
    output logic                imadd_sl,
    output logic                rb_data1_sl,
    output logic [1:0]          rb_datain_sl,
    output logic [1:0]          alu_data_sl,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                rb_we,
    output logic                dm_req,
    output logic                dm_we,
    input  logic                dm_ready,
    output logic [1:0]          seg_sl,
    output logic                seg_we,
    output logic [1:0]          led_sl,
    output logic                led_we,
    output logic                illegal,
    output logic                bus_err,
    output logic                halted
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    instr_class_t        decClass;
    ctrl_word_t          decCtrl;
    logic [ALU_OP_W-1:0] decAluOp;

    state_t              state_q, state_d;
    instr_class_t        class_q;
    ctrl_word_t          ctrl_q;
    logic [ALU_OP_W-1:0] aluOp_q;
    logic [CNT_W-1:0]    memCount_q;
    logic [CNT_W-1:0]    memCountInc;
    logic                memTimeout;
    logic                illegal_q, busErr_q, halted_q;
    logic                imReq_q, dmReq_q, dmWe_q;
    logic                pcWe_q, rbWe_q, segWe_q, ledWe_q, branch_q;

    control_decode #(
        .INSTR_W (INSTR_W),
        .FUNC_W  (FUNC_W),
        .OP_W    (OP_W),
        .ALU_OP_W(ALU_OP_W)
    ) uDecode (
        .instr_i (instr),
        .class_o (decClass),
        .ctrl_o  (decCtrl),
        .aluOp_o (decAluOp)
    );

    // Next-state logic. The timeout fires on the MEM_TIMEOUT-th wait cycle,
    // and a dm_ready arriving on that same cycle still completes the access.
    always_comb begin
        memCountInc = memCount_q + CNT_W'(1);
        memTimeout  = (memCountInc == CNT_W'(MEM_TIMEOUT));
        state_d     = state_q;
        case (state_q)
            ST_FETCH:  if (im_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = (class_q == CL_ILLEGAL) ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_d = (class_q == CL_LOAD || class_q == CL_STORE) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dm_ready)        state_d = ST_WB;
                else if (memTimeout) state_d = ST_HALT;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // FSM state, captured instruction controls, timeout counter, sticky flags
    // and registered outputs. Outputs are computed from the next state so they
    // line up with the state they belong to; stall simply skips the update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            class_q    <= CL_NOP;
            ctrl_q     <= '0;
            aluOp_q    <= ALU_OP_W'(ALU_NOP);
            memCount_q <= '0;
            illegal_q  <= 1'b0;
            busErr_q   <= 1'b0;
            halted_q   <= 1'b0;
            imReq_q    <= 1'b1;
            dmReq_q    <= 1'b0;
            dmWe_q     <= 1'b0;
            pcWe_q     <= 1'b0;
            rbWe_q     <= 1'b0;
            segWe_q    <= 1'b0;
            ledWe_q    <= 1'b0;
            branch_q   <= 1'b0;
        end else if (!stall) begin
            state_q    <= state_d;
            memCount_q <= (state_q == ST_MEM) ? memCountInc : '0;

            imReq_q  <= (state_d == ST_FETCH);
            dmReq_q  <= (state_d == ST_MEM);
            dmWe_q   <= (state_d == ST_MEM) && (class_q == CL_STORE);
            halted_q <= (state_d == ST_HALT);
            pcWe_q   <= (state_d == ST_WB);
            rbWe_q   <= (state_d == ST_WB) && (class_q == CL_ALU || class_q == CL_LOAD);
            segWe_q  <= (state_d == ST_WB) && ctrl_q.segWe;
            ledWe_q  <= (state_d == ST_WB) && ctrl_q.ledWe;
            branch_q <= (state_d == ST_WB) && (class_q == CL_BRANCH);

            if (state_q == ST_DECODE && class_q == CL_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
            if (state_q == ST_MEM && !dm_ready && memTimeout) begin
                busErr_q <= 1'b1;
            end

            if (state_q == ST_FETCH && im_valid) begin
                class_q <= decClass;
                ctrl_q  <= decCtrl;
                aluOp_q <= decAluOp;
            end else if (state_d == ST_FETCH || state_d == ST_HALT) begin
                class_q <= CL_NOP;
                ctrl_q  <= '0;
                aluOp_q <= ALU_OP_W'(ALU_NOP);
            end
        end
    end

    // The fetch request is held low while reset is asserted; ir_we follows
    // im_valid in the same cycle so the datapath latches the word it is given.
    // Write strobes are masked by stall and fire on the first unstalled WB cycle.
    assign im_req       = imReq_q && rst_n;
    assign ir_we        = (state_q == ST_FETCH) && im_valid && !stall && rst_n;
    assign pc_we        = pcWe_q && !stall;
    assign rb_we        = rbWe_q && !stall;
    assign seg_we       = segWe_q && !stall;
    assign led_we       = ledWe_q && !stall;
    assign branch       = branch_q;
    assign dm_req       = dmReq_q;
    assign dm_we        = dmWe_q;
    assign halted       = halted_q;
    assign illegal      = illegal_q;
    assign bus_err      = busErr_q;
    assign imadd_sl     = ctrl_q.imaddSl;
    assign rb_data1_sl  = ctrl_q.rbData1Sl;
    assign rb_datain_sl = ctrl_q.rbDatainSl;
    assign alu_data_sl  = ctrl_q.aluDataSl;
    assign seg_sl       = ctrl_q.segSl;
    assign led_sl       = ctrl_q.ledSl;
    assign alu_op       = aluOp_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed bench for the multi-cycle control unit: ALU, load, store, branch,
// NOP, IO with stall, reset during MEM, bus timeout and illegal opcode.
// Strobe vector bit order: ir_we pc_we rb_we seg_we led_we branch dm_req dm_we im_req
// Select vector bit order: imadd rbData1 rbDatain[1:0] aluData[1:0] seg[1:0] led[1:0]
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       im_req;
    logic       im_valid;
    logic [15:0] instr;
    logic       ir_we, pc_we, branch, imadd_sl, rb_data1_sl;
    logic [1:0] rb_datain_sl, alu_data_sl, seg_sl, led_sl;
    logic [3:0] alu_op;
    logic       rb_we, dm_req, dm_we, dm_ready, seg_we, led_we;
    logic       illegal, bus_err, halted;

    int checks;
    int errors;

    logic [8:0] strobes;
    logic [9:0] selects;
    logic [2:0] flags;

    localparam logic [8:0] S_IDLE    = 9'b000000000;
    localparam logic [8:0] S_FETCH   = 9'b000000001;
    localparam logic [8:0] S_FETCH_V = 9'b100000001;
    localparam logic [8:0] S_WB_RB   = 9'b011000000;
    localparam logic [8:0] S_WB_PC   = 9'b010000000;
    localparam logic [8:0] S_WB_BR   = 9'b010001000;
    localparam logic [8:0] S_WB_SEG  = 9'b010100000;
    localparam logic [8:0] S_MEM_RD  = 9'b000000100;
    localparam logic [8:0] S_MEM_WR  = 9'b000000110;

    assign strobes = {ir_we, pc_we, rb_we, seg_we, led_we, branch, dm_req, dm_we, im_req};
    assign selects = {imadd_sl, rb_data1_sl, rb_datain_sl, alu_data_sl, seg_sl, led_sl};
    assign flags   = {illegal, bus_err, halted};

    multicycle_control_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .im_req       (im_req),
        .im_valid     (im_valid),
        .instr        (instr),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .branch       (branch),
        .imadd_sl     (imadd_sl),
        .rb_data1_sl  (rb_data1_sl),
        .rb_datain_sl (rb_datain_sl),
        .alu_data_sl  (alu_data_sl),
        .alu_op       (alu_op),
        .rb_we        (rb_we),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_ready     (dm_ready),
        .seg_sl       (seg_sl),
        .seg_we       (seg_we),
        .led_sl       (led_sl),
        .led_we       (led_we),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .halted       (halted)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not complete, observed timeout expected finish");
        $fatal(1);
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic rdy, input logic st, input logic [15:0] ins);
        im_valid = v;
        dm_ready = rdy;
        stall    = st;
        instr    = ins;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    // Present one instruction in FETCH, check ir_we, and land in DECODE
    task automatic fetchInstr(input logic [15:0] ins, input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, ins);
        checkOutput({tag, "-fetch"}, 32'(strobes), 32'(S_FETCH_V));
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        im_valid = 1'b0;
        instr    = 16'h0000;
        dm_ready = 1'b0;

        // Reset state
        nextCycle();
        nextCycle();
        #1;
        checkOutput("reset-strobes", 32'(strobes), 32'(S_IDLE));
        checkOutput("reset-aluop",   32'(alu_op),  32'hF);
        checkOutput("reset-flags",   32'(flags),   32'h0);
        checkOutput("reset-selects", 32'(selects), 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("fetch-idle", 32'(strobes), 32'(S_FETCH));

        // R-type ADD: ir_we c0, alu_op 0000 c1..c3, rb_we+pc_we at c3
        fetchInstr(16'h0040, "add");
        checkOutput("add-c1-strobes", 32'(strobes), 32'(S_IDLE));
        checkOutput("add-c1-aluop",   32'(alu_op),  32'h0);
        idleCycle();
        checkOutput("add-c2-strobes", 32'(strobes), 32'(S_IDLE));
        checkOutput("add-c2-aluop",   32'(alu_op),  32'h0);
        idleCycle();
        checkOutput("add-c3-strobes", 32'(strobes), 32'(S_WB_RB));
        checkOutput("add-c3-aluop",   32'(alu_op),  32'h0);
        idleCycle();
        checkOutput("add-c4-strobes", 32'(strobes), 32'(S_FETCH));
        checkOutput("add-c4-aluop",   32'(alu_op),  32'hF);

        // LOAD with dm_ready in the third MEM cycle
        fetchInstr(16'h8800, "load");
        checkOutput("load-dec-selects", 32'(selects), 32'h050);
        idleCycle();
        checkOutput("load-exec", 32'(strobes), 32'(S_IDLE));
        idleCycle();
        checkOutput("load-mem1", 32'(strobes), 32'(S_MEM_RD));
        idleCycle();
        checkOutput("load-mem2", 32'(strobes), 32'(S_MEM_RD));
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("load-mem3", 32'(strobes), 32'(S_MEM_RD));
        idleCycle();
        checkOutput("load-wb",         32'(strobes), 32'(S_WB_RB));
        checkOutput("load-wb-selects", 32'(selects), 32'h050);
        idleCycle();
        checkOutput("load-fetch",         32'(strobes), 32'(S_FETCH));
        checkOutput("load-fetch-selects", 32'(selects), 32'h0);

        // STORE with dm_ready on the last allowed MEM cycle
        fetchInstr(16'h9000, "store");
        checkOutput("store-dec-selects", 32'(selects), 32'h110);
        idleCycle();
        for (int i = 1; i <= 14; i++) begin
            idleCycle();
            checkOutput("store-mem-wait", 32'(strobes), 32'(S_MEM_WR));
        end
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("store-mem15", 32'(strobes), 32'(S_MEM_WR));
        idleCycle();
        checkOutput("store-wb",       32'(strobes), 32'(S_WB_PC));
        checkOutput("store-wb-flags", 32'(flags),   32'h0);
        idleCycle();
        checkOutput("store-fetch", 32'(strobes), 32'(S_FETCH));

        // BRANCH
        fetchInstr(16'h9800, "beq");
        checkOutput("beq-dec-selects", 32'(selects), 32'h200);
        checkOutput("beq-dec-aluop",   32'(alu_op),  32'h1);
        idleCycle();
        idleCycle();
        checkOutput("beq-wb", 32'(strobes), 32'(S_WB_BR));
        idleCycle();

        // NOP: only pc_we
        fetchInstr(16'h0000, "nop");
        idleCycle();
        idleCycle();
        checkOutput("nop-wb", 32'(strobes), 32'(S_WB_PC));
        idleCycle();

        // 7-seg write with 5 stalled EXEC cycles, then a stalled WB cycle
        fetchInstr(16'hA800, "seg");
        checkOutput("seg-dec-selects", 32'(selects), 32'h004);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
        checkOutput("seg-stall1", 32'(strobes), 32'(S_IDLE));
        for (int i = 2; i <= 5; i++) begin
            nextCycle();
            checkOutput("seg-stall-strobes", 32'(strobes), 32'(S_IDLE));
            checkOutput("seg-stall-selects", 32'(selects), 32'h004);
        end
        idleCycle();
        checkOutput("seg-exec-resume", 32'(strobes), 32'(S_IDLE));
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
        checkOutput("seg-wb-stalled", 32'(strobes), 32'(S_IDLE));
        idleCycle();
        checkOutput("seg-wb", 32'(strobes), 32'(S_WB_SEG));
        idleCycle();
        checkOutput("seg-fetch", 32'(strobes), 32'(S_FETCH));

        // Reset while a LOAD waits in MEM
        fetchInstr(16'h8800, "rstmem");
        idleCycle();
        idleCycle();
        checkOutput("rstmem-mem1", 32'(strobes), 32'(S_MEM_RD));
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("rstmem-after",       32'(strobes), 32'(S_FETCH));
        checkOutput("rstmem-after-flags", 32'(flags),   32'h0);
        idleCycle();
        checkOutput("rstmem-no-wb", 32'(strobes), 32'(S_FETCH));

        // STORE that never sees dm_ready: bus error and halt
        fetchInstr(16'h9000, "tmo");
        idleCycle();
        for (int i = 1; i <= 15; i++) begin
            idleCycle();
            checkOutput("tmo-mem-wait", 32'(strobes), 32'(S_MEM_WR));
        end
        idleCycle();
        checkOutput("tmo-halt-strobes", 32'(strobes), 32'(S_IDLE));
        checkOutput("tmo-halt-flags",   32'(flags),   32'b011);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0040);
        checkOutput("tmo-halt-hold", 32'(strobes), 32'(S_IDLE));
        rst_n = 1'b0;
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("tmo-reset-flags", 32'(flags), 32'h0);
        rst_n = 1'b1;
        #1;

        // Undefined R-type function: illegal, halted, no strobes until reset
        fetchInstr(16'h01C0, "ill");
        checkOutput("ill-dec-strobes", 32'(strobes), 32'(S_IDLE));
        idleCycle();
        checkOutput("ill-halt-flags",   32'(flags),   32'b101);
        checkOutput("ill-halt-strobes", 32'(strobes), 32'(S_IDLE));
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0040);
            checkOutput("ill-hold-flags",   32'(flags),   32'b101);
            checkOutput("ill-hold-strobes", 32'(strobes), 32'(S_IDLE));
        end
        rst_n = 1'b0;
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("ill-reset-flags",   32'(flags),   32'h0);
        checkOutput("ill-reset-strobes", 32'(strobes), 32'(S_IDLE));
        checkOutput("ill-reset-aluop",   32'(alu_op),  32'hF);
        rst_n = 1'b1;
        #1;
        checkOutput("ill-release", 32'(strobes), 32'(S_FETCH));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
